// File: rtl/fan_ramp_ctrl.sv
// Soft-start/soft-stop fan PWM controller: ramps duty toward the selected level at PWM period boundaries.
// Optional kick-start burst from standstill is enabled by defining FAN_KICK_EN.
module fan_ramp_ctrl #(
  parameter int unsigned PERIOD       = 270000,
  parameter int unsigned STEP         = 10000,
  parameter int unsigned L1_DUTY      = 70000,
  parameter int unsigned L2_DUTY      = 150000,
  parameter int unsigned L3_DUTY      = 250000,
  parameter int unsigned KICK_DUTY    = 250000,
  parameter int unsigned KICK_PERIODS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_stop,
  input  logic        req_l1,
  input  logic        req_l2,
  input  logic        req_l3,
  input  logic        timer_expire,
  output logic        pwm_out,
  output logic [19:0] duty,
  output logic [1:0]  level,
  output logic [2:0]  led,
  output logic        busy,
  output logic        period_tick
);

  localparam logic [19:0] CNT_MAX = 20'(PERIOD - 1);
  localparam logic [19:0] STEP_D  = 20'(STEP);
  localparam logic [20:0] STEP_W  = 21'(STEP);
  localparam logic [19:0] L1_D    = 20'(L1_DUTY);
  localparam logic [19:0] L2_D    = 20'(L2_DUTY);
  localparam logic [19:0] L3_D    = 20'(L3_DUTY);

  if (KICK_PERIODS < 1 || L3_DUTY >= PERIOD || KICK_DUTY >= PERIOD || PERIOD > 1048576) begin : g_param_check
    $error("fan_ramp_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_RAMP_DOWN,
    S_HOLD
`ifdef FAN_KICK_EN
    , S_KICK
`endif
  } state_t;

  state_t      state, state_n;
  logic [19:0] cnt;
  logic [19:0] duty_n;
  logic [19:0] target;
  logic [20:0] d_ext, t_ext, up_sum, dn_lim;

`ifdef FAN_KICK_EN
  localparam int unsigned KW     = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [19:0] KICK_D = 20'(KICK_DUTY);
  localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS - 1);
  logic [KW-1:0] kick_cnt, kick_n;
`endif

  assign period_tick = (cnt == CNT_MAX);
  assign pwm_out     = (duty > cnt);
  assign busy        = (state != S_IDLE) && (state != S_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (period_tick) cnt <= '0;
    else cnt <= cnt + 20'd1;
  end

  // Expiry dominates; otherwise the highest-priority pulse wins and idle cycles hold the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level <= '0;
    else if (timer_expire || req_stop) level <= 2'd0;
    else if (req_l1) level <= 2'd1;
    else if (req_l2) level <= 2'd2;
    else if (req_l3) level <= 2'd3;
  end

  always_comb begin
    target = '0;
    led    = '0;
    case (level)
      2'd1: begin target = L1_D; led = 3'b100; end
      2'd2: begin target = L2_D; led = 3'b010; end
      2'd3: begin target = L3_D; led = 3'b001; end
      default: ;
    endcase
  end

  assign d_ext  = {1'b0, duty};
  assign t_ext  = {1'b0, target};
  assign up_sum = d_ext + STEP_W;
  assign dn_lim = t_ext + STEP_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      duty  <= '0;
`ifdef FAN_KICK_EN
      kick_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      duty  <= duty_n;
`ifdef FAN_KICK_EN
      kick_cnt <= kick_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
`ifdef FAN_KICK_EN
    kick_n  = kick_cnt;
`endif
    if (period_tick) begin
      case (state)
        S_IDLE: begin
          if (target != '0) begin
`ifdef FAN_KICK_EN
            state_n = S_KICK;
            duty_n  = KICK_D;
            kick_n  = KICK_LOAD;
`else
            state_n = S_RAMP_UP;
            duty_n  = (STEP_W >= t_ext) ? target : STEP_D;
`endif
          end
        end
`ifdef FAN_KICK_EN
        S_KICK: begin
          if (target == '0) begin
            state_n = S_IDLE;
            duty_n  = '0;
          end else if (kick_cnt == '0) begin
            state_n = S_HOLD;
            duty_n  = target;
          end else begin
            kick_n = kick_cnt - 1'b1;
          end
        end
`endif
        S_RAMP_UP: begin
          if (t_ext < d_ext) begin
            state_n = S_RAMP_DOWN;
          end else if (up_sum >= t_ext) begin
            state_n = S_HOLD;
            duty_n  = target;
          end else begin
            duty_n = duty + STEP_D;
          end
        end
        S_RAMP_DOWN: begin
          if (t_ext > d_ext) begin
            state_n = S_RAMP_UP;
          end else if (d_ext <= dn_lim) begin
            duty_n  = target;
            state_n = (target == '0) ? S_IDLE : S_HOLD;
          end else begin
            duty_n = duty - STEP_D;
          end
        end
        S_HOLD: begin
          if (t_ext > d_ext) begin
            state_n = S_RAMP_UP;
            duty_n  = (up_sum >= t_ext) ? target : duty + STEP_D;
          end else if (t_ext < d_ext) begin
            if (d_ext <= dn_lim) begin
              duty_n  = target;
              state_n = (target == '0) ? S_IDLE : S_RAMP_DOWN;
            end else begin
              state_n = S_RAMP_DOWN;
              duty_n  = duty - STEP_D;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          duty_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fan_ramp_ctrl.md
# fan_ramp_ctrl

Soft-start/soft-stop speed controller for the fan motor PWM stage. It takes debounced single-cycle speed requests (stop, level 1–3) and a sleep-timer expiry level. It sequences the PWM duty toward the selected target in fixed steps at PWM-period boundaries, with an optional kick-start burst when spinning up from standstill. It sits between the switch-conditioning logic and the motor driver pin, replacing the direct duty-load path.

## Interface
Parameters:
- PERIOD, 270000: PWM period in clk cycles (200 Hz at 54 MHz); must be ≤ 2^20.
- STEP, 10000: duty change per PWM period while ramping.
- L1_DUTY, 70000: level-1 target duty.
- L2_DUTY, 150000: level-2 target duty.
- L3_DUTY, 250000: level-3 target duty; must be < PERIOD.
- KICK_DUTY, 250000: duty applied during kick-start.
- KICK_PERIODS, 20: kick-start length in PWM periods; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_stop  in  1  single-cycle pulse; select target 0.
- req_l1  in  1  single-cycle pulse; select L1_DUTY.
- req_l2  in  1  single-cycle pulse; select L2_DUTY.
- req_l3  in  1  single-cycle pulse; select L3_DUTY.
- timer_expire  in  1  level; while high, forces target 0 and ignores level requests.
- pwm_out  out  1  motor PWM, equal to (duty > cnt).
- duty  out  20  current applied duty.
- level  out  2  selected target: 0 = stop, 1–3 = level.
- led  out  3  one-hot target indicator: L1 = 100, L2 = 010, L3 = 001, stop = 000.
- busy  out  1  high in KICK, RAMP_UP or RAMP_DOWN.
- period_tick  out  1  high for one cycle when cnt == PERIOD-1.

## Operation
- Period counter cnt (20 bits) counts 0..PERIOD-1 and wraps to 0. It free-runs in every state.
- Target select:
  - Priority is req_stop > req_l1 > req_l2 > req_l3 when requests arrive in the same cycle.
  - timer_expire high overrides everything and sets level to 0.
  - A request equal to the current level is a no-op.
- duty changes only on the clock edge where period_tick = 1. This keeps each period glitch-free.
- FSM, evaluated only at period_tick (T = target duty, D = duty):
  - IDLE (D = 0):
    - T ≠ 0 with FAN_KICK_EN: go to KICK, D = KICK_DUTY, kick_cnt = KICK_PERIODS-1.
    - T ≠ 0 without the macro: go to RAMP_UP, D = min(STEP, T).
  - KICK:
    - T = 0: go to IDLE, D = 0.
    - kick_cnt = 0: D = T, go to HOLD.
    - Otherwise decrement kick_cnt.
  - RAMP_UP:
    - T < D: go to RAMP_DOWN with no step this tick.
    - D + STEP ≥ T: D = T, go to HOLD.
    - Otherwise D += STEP.
  - RAMP_DOWN:
    - T > D: go to RAMP_UP with no step this tick.
    - D ≤ T + STEP: D = T, then go to IDLE if T = 0, else HOLD.
    - Otherwise D -= STEP.
  - HOLD:
    - T > D: go to RAMP_UP and apply the first +STEP this tick, clamped to T.
    - T < D: go to RAMP_DOWN and apply the first −STEP this tick, clamped to T. If the clamp reaches T = 0, go directly to IDLE.
- Arithmetic uses 21-bit intermediates so D + STEP cannot overflow. D never exceeds max(T, KICK_DUTY) and never drops below 0.
- Stop and timer expiry both use a soft ramp-down; neither cuts duty abruptly, except from KICK.

## Timing
- Reset values: cnt = 0, duty = 0, pwm_out = 0, level = 0, led = 000, busy = 0, period_tick = 0, FSM in IDLE, kick_cnt = 0.
- Request pulse at cycle t: level and led are updated at t+1. duty is first affected on the edge after the next period_tick.
- timer_expire is sampled every cycle. Its effect on level is the same as req_stop, and it holds while the input stays high.
- Full ramp 0→L3 without kick: 25 period_ticks. Reverse ramp L3→0: 25 period_ticks.
- Reset asserted mid-ramp: all state clears immediately (asynchronous). After release, the block restarts in IDLE with target 0.
- pwm_out is combinational from registered duty and cnt. It is high for exactly D cycles per period.

## Configuration
- FAN_KICK_EN defined:
  - The KICK state exists.
  - Spin-up from IDLE applies KICK_DUTY for KICK_PERIODS periods.
  - It then jumps straight to the target and enters HOLD.
- FAN_KICK_EN undefined:
  - KICK state and kick_cnt are not compiled.
  - Spin-up from IDLE always ramps from STEP.

## Test plan
- Reset, then req_l2 with no kick: level = 2, led = 010 at t+1. duty goes 10000, 20000, … 150000 over 15 ticks, then HOLD and busy = 0.
- In HOLD at L3, pulse req_l1: duty steps down 250000→70000 in 18 ticks and settles at 70000 in HOLD.
- Reach L1, then pulse req_stop: duty goes 60000 … 0 and the FSM reaches IDLE. pwm_out stays low for a whole period.
- req_l1 and req_l3 in the same cycle: level = 1. timer_expire high during an L3 hold: level = 0 and duty ramps to 0; req_l2 pulses are ignored while expiry is high.
- FAN_KICK_EN with req_l1 from IDLE: duty = 250000 for 20 periods, then 70000 in HOLD. req_stop during kick: duty = 0 at the next tick.
- Assert reset mid-ramp at duty 120000: duty, pwm_out and level are 0 immediately. After release with no request, the block remains in IDLE.
